// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared ALU control codes and issue-FSM state encoding for the mul/div issue controller.
package muldiv_issue_ctrl_pkg;

  localparam int ALU_CTL_BITS = 4;

  localparam logic [ALU_CTL_BITS-1:0] ALU_CTL_MULT = 4'd8;
  localparam logic [ALU_CTL_BITS-1:0] ALU_CTL_DIV  = 4'd9;
  localparam logic [ALU_CTL_BITS-1:0] ALU_CTL_MFHI = 4'd10;
  localparam logic [ALU_CTL_BITS-1:0] ALU_CTL_MFLO = 4'd11;
  localparam logic [ALU_CTL_BITS-1:0] ALU_CTL_MTHI = 4'd12;
  localparam logic [ALU_CTL_BITS-1:0] ALU_CTL_MTLO = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_hilo_reg.sv
// Architectural HI/LO pair: independent write enables, one read port selected by MFHI/MFLO.
module muldiv_hilo_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_hi_i,
  input  logic        we_lo_i,
  input  logic [31:0] hi_d_i,
  input  logic [31:0] lo_d_i,
  input  logic        rd_hi_i,
  output logic [31:0] rd_o
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (we_hi_i) r_hi <= hi_d_i;
      if (we_lo_i) r_lo <= lo_d_i;
    end
  end

  assign rd_o = rd_hi_i ? r_hi : r_lo;

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Issue/writeback controller between EX and the iterative mul/div core, with
// divide-by-zero short-circuit, EX interlock and a watchdog on the core.
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ALU_CTL_BITS-1:0] ALUCtl_i,
  input  logic                    valid_i,
  input  logic [31:0]             Op1_i,
  input  logic [31:0]             Op2_i,
  output logic [31:0]             Res_o,
  output logic                    Stall_o,
  output logic                    md_start_o,
  output logic                    md_div_o,
  output logic [31:0]             md_op1_o,
  output logic [31:0]             md_op2_o,
  input  logic                    md_done_i,
  input  logic [31:0]             md_hi_i,
  input  logic [31:0]             md_lo_i,
  output logic                    divz_o,
  output logic                    timeout_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  md_state_t          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_start;
  logic               r_div;
  logic [31:0]        r_op1;
  logic [31:0]        r_op2;
  logic               r_divz;
  logic               r_timeout;

  logic        w_mult, w_div, w_mfhi, w_mflo, w_mthi, w_mtlo;
  logic        w_ours, w_idle, w_acc, w_launch, w_divz, w_done;
  logic        w_we_hi, w_we_lo;
  logic [31:0] w_hi_d, w_lo_d, w_rd;

  assign w_mult = (ALUCtl_i == ALU_CTL_MULT);
  assign w_div  = (ALUCtl_i == ALU_CTL_DIV);
  assign w_mfhi = (ALUCtl_i == ALU_CTL_MFHI);
  assign w_mflo = (ALUCtl_i == ALU_CTL_MFLO);
  assign w_mthi = (ALUCtl_i == ALU_CTL_MTHI);
  assign w_mtlo = (ALUCtl_i == ALU_CTL_MTLO);
  assign w_ours = w_mult | w_div | w_mfhi | w_mflo | w_mthi | w_mtlo;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_acc    = valid_i & w_idle;
  assign w_divz   = w_acc & w_div & (Op2_i == '0);
  assign w_launch = w_acc & (w_mult | (w_div & (Op2_i != '0)));
  // A done pulse outside RUN (stale after reset or timeout) must never reach HI/LO.
  assign w_done   = (r_state == ST_RUN) & md_done_i;

  assign w_we_hi = w_done | w_divz | (w_acc & w_mthi);
  assign w_we_lo = w_done | w_divz | (w_acc & w_mtlo);
  assign w_hi_d  = w_done ? md_hi_i : Op1_i;
  assign w_lo_d  = w_done ? md_lo_i : (w_divz ? '1 : Op1_i);

  muldiv_hilo_reg u_hilo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_hi_i (w_we_hi),
    .we_lo_i (w_we_lo),
    .hi_d_i  (w_hi_d),
    .lo_d_i  (w_lo_d),
    .rd_hi_i (w_mfhi),
    .rd_o    (w_rd)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_start   <= 1'b0;
      r_div     <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_divz    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_op1   <= Op1_i;
            r_op2   <= Op2_i;
            r_div   <= w_div;
            r_divz  <= 1'b0;
            r_start <= 1'b1;
            r_state <= ST_LAUNCH;
          end else if (w_divz) begin
            r_divz <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (md_done_i) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Stall_o    = valid_i & w_ours & ~w_idle;
  assign Res_o      = (w_acc & (w_mfhi | w_mflo)) ? w_rd : '0;
  assign md_start_o = r_start;
  assign md_div_o   = r_div;
  assign md_op1_o   = r_op1;
  assign md_op2_o   = r_op2;
  assign divz_o     = r_divz;
  assign timeout_o  = r_timeout;

endmodule

// File: doc/muldiv_issue_ctrl.md
# muldiv_issue_ctrl

Issue and writeback controller between the EX stage and the iterative multiply/divide core. It accepts MULT/DIV from EX, launches the core with operands held stable, and writes the 64-bit result into architectural HI/LO. It serves MFHI/MFLO/MTHI/MTLO and interlocks EX with a stall while an operation is in flight. It also handles divide-by-zero without launching the core, and a watchdog timeout.

## Interface
- TIMEOUT, 40: maximum core cycles, counted from md_start_o, before the operation is abandoned.
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- ALUCtl_i  in  `ALU_CTL_BITS  decoded EX op: MULT, DIV, MFHI, MFLO, MTHI, MTLO; any other value is a no-op here.
- valid_i  in  1  EX instruction valid (not a bubble, not flushed).
- Op1_i  in  32  rs operand: dividend, multiplicand, or MTHI/MTLO data.
- Op2_i  in  32  rt operand: divisor or multiplier.
- Res_o  out  32  MFHI/MFLO read data; 0 otherwise.
- Stall_o  out  1  stall EX and every stage upstream of it.
- md_start_o  out  1  one-cycle start pulse to the core.
- md_div_o  out  1  1 = divide, 0 = multiply; stable while busy.
- md_op1_o, md_op2_o  out  32  operands; stable from the start pulse until done.
- md_done_i  in  1  core completion pulse.
- md_hi_i, md_lo_i  in  32  core result; sampled only in the md_done_i cycle.
- divz_o  out  1  last accepted DIV had a zero divisor.
- timeout_o  out  1  sticky watchdog flag.

## Operation
- Ops are accepted only when valid_i=1; with valid_i=0 nothing changes.
- States:
  - IDLE: no operation in flight.
  - LAUNCH: single cycle; md_start_o=1.
  - RUN: waiting for md_done_i.
- IDLE with MULT or DIV, divisor ≠0:
  - Latch Op1_i/Op2_i into md_op1_o/md_op2_o; latch md_div_o.
  - Clear divz_o. Go to LAUNCH.
  - No stall: the instruction retires.
- IDLE with DIV, Op2_i=0:
  - Core is not launched.
  - HI←Op1_i, LO←32'hFFFF_FFFF, divz_o←1.
  - State stays IDLE.
- LAUNCH: go to RUN; cycle counter ←0.
- RUN with md_done_i=1: HI←md_hi_i, LO←md_lo_i; go to IDLE.
- RUN with md_done_i=0: counter +1. If counter==TIMEOUT-1:
  - timeout_o←1; HI/LO unchanged; go to IDLE.
- MTHI/MTLO in IDLE: HI or LO ←Op1_i at the clock edge.
- MFHI/MFLO in IDLE: Res_o = HI or LO combinationally.
  - HI/LO written in cycle t is visible in cycle t+1. There is no same-cycle bypass; none is needed because the writer is never in EX at the same time.
- Stall_o = valid_i & (op ∈ {MULT, DIV, MFHI, MFLO, MTHI, MTLO}) & state≠IDLE.
  - While Stall_o=1, Res_o=0 and no HI/LO/operand write occurs.
  - EX holds ALUCtl_i/Op*_i stable during a stall.
- md_done_i outside RUN is ignored, including a stale done after reset or after a timeout.
- Counter width: $clog2(TIMEOUT).

## Timing
- Reset values: state IDLE, HI=LO=0, md_op1_o=md_op2_o=0, md_div_o=0, md_start_o=0, Stall_o=0, Res_o=0, divz_o=0, timeout_o=0, counter 0.
- Reset mid-operation abandons the op. The core is not notified; its later done is ignored.
- MULT/DIV accepted in cycle t:
  - md_start_o=1 in t+1.
  - Core done at t+1+L (L ≥1): HI/LO written at the end of that cycle.
  - State is IDLE at t+2+L; a stalled MF* completes in that cycle with the new value.
- Back-to-back MULT at t+1 stalls until t+2+L, is accepted then, and launches at t+3+L.
- Divide-by-zero: one cycle, zero stall.
- Timeout: no done by cycle t+1+TIMEOUT → timeout_o set; IDLE at t+2+TIMEOUT.

## Structure
- Def.v gains `ALU_CTL_MTHI and `ALU_CTL_MTLO next to the existing MULT/DIV/MFHI/MFLO codes.
- Def.v also gains the state encodings (IDLE/LAUNCH/RUN, 2 bits).
- One sub-module: muldiv_hilo_reg.
  - Contents: HI/LO pair with two independent write enables and a read mux selected by MFHI/MFLO.
  - The remaining FSM, counter and operand latches stay in muldiv_issue_ctrl.

## Test plan
- Reset, then MFLO: Res_o=0, Stall_o=0. MTHI 0x1234_5678 then MFHI next cycle → Res_o=0x1234_5678.
- MULT 7×(-3), core model L=33, MFLO issued at t+1:
  - Stall_o=1 for t+1..t+34.
  - Res_o=0xFFFF_FFEB at t+35; MFHI → 0xFFFF_FFFF.
- DIV 100/0:
  - md_start_o never pulses; divz_o=1.
  - MFHI=100, MFLO=0xFFFF_FFFF.
  - Then MULT 2×2 clears divz_o.
- DIV -7/2 immediately followed by DIV 9/4:
  - Second op stalls and launches only after the first done.
  - Final HI=1, LO=2.
- Core never asserts done: timeout_o=1 at t+1+TIMEOUT; HI/LO keep their prior values; stall released. A later stale md_done_i with 0xDEAD in hi/lo leaves HI/LO unchanged.
- Assert rst_i during RUN:
  - All outputs return to reset values next cycle.
  - A done pulse 5 cycles later leaves HI=LO=0.
